// File: rtl/dma_arbiter_pkg.sv
// Shared arbiter FSM encoding, key-memory defaults and the region check
// reused by the key-protection monitors.
package dma_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ERR  = 2'd2,
        KILL = 2'd3
    } arb_state_t;

    localparam logic [15:0] KMEM_BASE_DEF     = 16'hFEFE;
    localparam logic [15:0] KMEM_SIZE_DEF     = 16'h001F;
    localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;
    localparam int          MAX_LOCK_DEF      = 8;

    // Half-open [base, base+size) compared on 17 bits so the top end never wraps.
    function automatic logic in_kmem(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] size);
        logic [16:0] a17;
        logic [16:0] lo17;
        logic [16:0] hi17;
        a17  = {1'b0, addr};
        lo17 = {1'b0, base};
        hi17 = lo17 + {1'b0, size};
        return (a17 >= lo17) && (a17 < hi17);
    endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Two-way round-robin picker: one-hot winner, requester at ptr has priority.
// Latency: combinational.
// Backpressure: none; an empty request vector yields an all-zero winner.
module dma_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    assign win = (ptr == 1'b0) ? (req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00))
                               : (req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00));

endmodule

// File: rtl/dma_arbiter.sv
// Two-requester DMA port arbiter with key-memory protection; DMA_ARB_LOCK_EN adds locked bursts.
// Latency: grant and dma_en one cycle after a request in IDLE; done/err registered one cycle later.
// Backpressure: dma_en holds until dma_ready; losers keep requesting and are never dropped.
module dma_arbiter
    import dma_arbiter_pkg::*;
#(
    parameter logic [15:0] KMEM_BASE     = KMEM_BASE_DEF,
    parameter logic [15:0] KMEM_SIZE     = KMEM_SIZE_DEF,
    parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF,
    parameter int          MAX_LOCK      = MAX_LOCK_DEF
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic        r0_req,
    input  logic [15:0] r0_addr,
    input  logic        r0_we,
    input  logic        r0_lock,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic [15:0] r1_addr,
    input  logic        r1_we,
    input  logic        r1_lock,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic        dma_en,
    output logic [15:0] dma_addr,
    output logic        dma_we,
    input  logic        dma_ready,
    output logic        kill
);

`ifdef DMA_ARB_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    localparam int             LCW       = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

    arb_state_t     state_q, state_d;
    logic           owner_q, owner_d;
    logic           ptr_q, ptr_d;
    logic [15:0]    addr_q, addr_d;
    logic           we_q, we_d;
    logic [1:0]     done_q, done_d;
    logic           kill_q, kill_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

    logic [1:0]  req_eff;
    logic [1:0]  win;
    logic        win_idx;
    logic [15:0] win_addr;
    logic        win_we;
    logic        own_req;
    logic        own_lock;
    logic [15:0] own_addr;
    logic        own_we;
    logic        chain;
    logic        kmem_req;

    // A requester whose done is pulsing still holds req this cycle; masking it
    // keeps the same transfer from being granted twice.
    assign req_eff = {r1_req, r0_req} & ~done_q;

    dma_rr_pick u_pick (
        .req (req_eff),
        .ptr (ptr_q),
        .win (win)
    );

    assign win_idx  = win[1];
    assign win_addr = win_idx ? r1_addr : r0_addr;
    assign win_we   = win_idx ? r1_we   : r0_we;

    assign own_req  = owner_q ? r1_req  : r0_req;
    assign own_lock = owner_q ? r1_lock : r0_lock;
    assign own_addr = owner_q ? r1_addr : r0_addr;
    assign own_we   = owner_q ? r1_we   : r0_we;

    assign chain    = LOCK_EN & own_lock & own_req & (lock_cnt_q < LOCK_LAST);
    assign kmem_req = (r0_req && in_kmem(r0_addr, KMEM_BASE, KMEM_SIZE)) ||
                      (r1_req && in_kmem(r1_addr, KMEM_BASE, KMEM_SIZE));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        we_d       = we_q;
        done_d     = 2'b00;
        kill_d     = kill_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            IDLE: begin
                if (win != 2'b00) begin
                    owner_d = win_idx;
                    if (in_kmem(win_addr, KMEM_BASE, KMEM_SIZE)) begin
                        state_d = ERR;
                    end else begin
                        state_d = XFER;
                        addr_d  = win_addr;
                        we_d    = win_we;
                    end
                end
            end
            XFER: begin
                if (dma_ready) begin
                    ptr_d = ~owner_q;
                    if (chain && in_kmem(own_addr, KMEM_BASE, KMEM_SIZE)) begin
                        // The err pulse reports this requester; done is withheld so
                        // the two never coincide.
                        state_d    = ERR;
                        lock_cnt_d = '0;
                    end else if (chain) begin
                        done_d     = owner_q ? 2'b10 : 2'b01;
                        addr_d     = own_addr;
                        we_d       = own_we;
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end else begin
                        done_d     = owner_q ? 2'b10 : 2'b01;
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end
                end
            end
            ERR: begin
                state_d = KILL;
                kill_d  = 1'b1;
            end
            KILL: begin
                if (pc == RESET_HANDLER && !kmem_req) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: begin
                state_d = KILL;
                kill_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= KILL;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 2'b00;
            kill_q     <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            done_q     <= done_d;
            kill_q     <= kill_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign dma_en   = (state_q == XFER);
    assign dma_addr = dma_en ? addr_q : 16'h0000;
    assign dma_we   = dma_en & we_q;
    assign r0_gnt   = dma_en & ~owner_q;
    assign r1_gnt   = dma_en & owner_q;
    assign r0_err   = (state_q == ERR) & ~owner_q;
    assign r1_err   = (state_q == ERR) & owner_q;
    assign r0_done  = done_q[0];
    assign r1_done  = done_q[1];
    assign kill     = kill_q;

endmodule
